// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS datapath (R-type, lw, sw, beq, j, addi)
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   ir_opcode[5:0]        instr[31:26] from the IR
//   zero                  ALU zero flag (consumed by the datapath through pc_write_cond)
//   mem_ready             memory completes the current access this cycle
//   pc_write .. reg_write datapath write enables and mux selects
//   alu_src_a/b, ALUop    ALU operand selects and ALUControl opcode
//   pc_source             00=ALU result, 01=ALUOut, 10=jump target
//   instr_done            pulse on the last cycle of each instruction
//   error                 high while trapped in ERROR
//   state[3:0]            current state, for debug
// Outputs decode the state register only, except ir_write/pc_write in FETCH and
// instr_done in MEM_WR, which fire in the cycle the memory access completes.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] ir_opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] ALUop,
  output logic       instr_done,
  output logic       error,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    ERROR     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  // last count value before a still-waiting cycle becomes a timeout
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t     st;
  logic [7:0] cnt;
  // zero gates the PC load in the datapath; the FSM itself never branches on it
  logic       unused_zero;

  assign unused_zero = zero;
  assign state = st;

  function automatic state_t decode(input logic [5:0] op);
    case (op)
      OP_R:         return R_EXEC;
      OP_LW, OP_SW: return MEM_ADDR;
      OP_BEQ:       return BRANCH;
      OP_J:         return JUMP;
      OP_ADDI:      return ADDI_EXEC;
      default:      return ERROR;
    endcase
  endfunction

  // cnt defaults to 0 every cycle, so any entry into a wait state starts from zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      cnt <= '0;
      case (st)
        FETCH, MEM_RD, MEM_WR:
          if (mem_ready) st <= st == FETCH ? DECODE : st == MEM_RD ? MEM_WB : FETCH;
          else if (cnt == LAST) st <= ERROR;
          else cnt <= cnt + 8'd1;
        DECODE:    st <= decode(ir_opcode);
        MEM_ADDR:  st <= ir_opcode == OP_LW ? MEM_RD : ir_opcode == OP_SW ? MEM_WR : ERROR;
        R_EXEC:    st <= R_WB;
        ADDI_EXEC: st <= ADDI_WB;
        MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB: st <= FETCH;
        default:   st <= ERROR;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    ALUop         = 2'b00;
    instr_done    = 1'b0;
    error         = 1'b0;
    case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        ALUop     = 2'b10;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end
endmodule
